// File: rtl/bsg_manycore_pkg.sv
// Shared types for the manycore print path.
//
// Contents:
//   bsg_print_arb_state_e : lifecycle of the print arbiter
//     PRINT_ARB_RUN   - arbitration enabled
//     PRINT_ARB_DRAIN - every requester finished; waiting for the output register to empty
//     PRINT_ARB_DONE  - terminal until reset
package bsg_manycore_pkg;

    typedef enum logic [1:0] {
        PRINT_ARB_RUN   = 2'd0,
        PRINT_ARB_DRAIN = 2'd1,
        PRINT_ARB_DONE  = 2'd2
    } bsg_print_arb_state_e;

endpackage

// File: rtl/bsg_arb_round_robin.sv
// Round-robin arbiter with a one-hot grant.
//
// The search starts at the priority pointer and wraps. The pointer moves to the
// slot after the winner only when yumi_i is asserted, so stalled cycles do not
// rotate priority. After reset, requester 0 has the highest priority.
//
// Ports:
//   clk_i, reset_n_i : clock, async active-low reset
//   reqs_i           : per-requester request
//   en_i             : when low, no grant is produced
//   yumi_i           : grant consumed this cycle (must only be high with a grant)
//   grant_o          : one-hot grant, combinational from reqs_i/en_i
//   grant_id_o       : index of the granted requester (0 when no grant)
module bsg_arb_round_robin #(
    parameter int num_req_p = 4
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic [num_req_p-1:0]         reqs_i,
    input  logic                         en_i,
    input  logic                         yumi_i,
    output logic [num_req_p-1:0]         grant_o,
    output logic [$clog2(num_req_p)-1:0] grant_id_o
);

    localparam int id_width_lp = $clog2(num_req_p);
    localparam logic [id_width_lp-1:0] last_id_lp = id_width_lp'(num_req_p - 1);

    logic [id_width_lp-1:0] ptr_q, ptr_d;
    logic [id_width_lp-1:0] idx;
    logic                   found;

    // NOTE: every variable written in an always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        grant_o    = '0;
        grant_id_o = '0;
        found      = 1'b0;
        idx        = '0;
        for (int k = 0; k < num_req_p; k++) begin
            idx = id_width_lp'((int'(ptr_q) + k) % num_req_p);
            if (en_i && !found && reqs_i[idx]) begin
                grant_o[idx] = 1'b1;
                grant_id_o   = idx;
                found        = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (yumi_i) begin
            ptr_d = (grant_id_o == last_id_lp) ? '0 : grant_id_o + id_width_lp'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // its pre-edge inputs regardless of statement order.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/bsg_manycore_print_arbiter.sv
// Print arbiter: merges print packets from num_req_p requesters into one
// single-entry output register, round-robin, one packet per cycle.
//
// A requester whose granted packet carries finish_code_p is marked finished
// (sticky) and excluded from further arbitration; the finish packet itself is
// still forwarded. When every requester has finished the block drains its
// output register and then raises done_o permanently until reset.
//
// Ports:
//   clk_i, reset_n_i : clock, async active-low reset
//   req_v_i          : per-requester packet valid
//   req_addr_i       : per-requester address, requester i in slice i
//   req_data_i       : per-requester data, requester i in slice i
//   req_yumi_o       : one-hot consume, combinational from req_v_i
//   out_v_o          : output packet valid
//   out_addr_o       : output address
//   out_data_o       : output data
//   out_id_o         : source requester of the output packet
//   out_ready_i      : sink ready; transfer when out_v_o & out_ready_i
//   finished_o       : per-requester finished flags
//   done_o           : all requesters finished and output drained
module bsg_manycore_print_arbiter
    import bsg_manycore_pkg::*;
#(
    parameter int                    num_req_p     = 4,
    parameter int                    addr_width_p  = 32,
    parameter int                    data_width_p  = 32,
    parameter logic [data_width_p-1:0] finish_code_p = data_width_p'(32'hCAFE_C0DE)
) (
    input  logic                              clk_i,
    input  logic                              reset_n_i,
    input  logic [num_req_p-1:0]              req_v_i,
    input  logic [num_req_p*addr_width_p-1:0] req_addr_i,
    input  logic [num_req_p*data_width_p-1:0] req_data_i,
    output logic [num_req_p-1:0]              req_yumi_o,
    output logic                              out_v_o,
    output logic [addr_width_p-1:0]           out_addr_o,
    output logic [data_width_p-1:0]           out_data_o,
    output logic [$clog2(num_req_p)-1:0]      out_id_o,
    input  logic                              out_ready_i,
    output logic [num_req_p-1:0]              finished_o,
    output logic                              done_o
);

    localparam int id_width_lp = $clog2(num_req_p);

    bsg_print_arb_state_e state_q, state_d;

    logic [num_req_p-1:0]    finished_q, finished_d;
    logic                    out_v_q, out_v_d;
    logic [addr_width_p-1:0] out_addr_q, out_addr_d;
    logic [data_width_p-1:0] out_data_q, out_data_d;
    logic [id_width_lp-1:0]  out_id_q, out_id_d;

    logic [num_req_p-1:0]    grant;
    logic [id_width_lp-1:0]  grant_id;
    logic                    grant_v;
    logic                    xfer;
    logic                    load_ok;
    logic                    arb_en;
    logic [addr_width_p-1:0] sel_addr;
    logic [data_width_p-1:0] sel_data;
    logic                    sel_finish;

    assign xfer    = out_v_q & out_ready_i;
    // The register can accept a new packet when empty or emptying this cycle.
    assign load_ok = ~out_v_q | out_ready_i;
    // Reset gates the grant combinationally so no yumi escapes while held in reset.
    assign arb_en  = reset_n_i & (state_q == PRINT_ARB_RUN) & load_ok;

    bsg_arb_round_robin #(
        .num_req_p(num_req_p)
    ) rr (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .reqs_i    (req_v_i & ~finished_q),
        .en_i      (arb_en),
        .yumi_i    (grant_v),
        .grant_o   (grant),
        .grant_id_o(grant_id)
    );

    assign grant_v    = |grant;
    assign req_yumi_o = grant;

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < num_req_p; i++) begin
            if (grant[i]) begin
                sel_addr = req_addr_i[i*addr_width_p +: addr_width_p];
                sel_data = req_data_i[i*data_width_p +: data_width_p];
            end
        end
    end

    assign sel_finish = (sel_data == finish_code_p);

    always_comb begin
        out_v_d    = out_v_q;
        out_addr_d = out_addr_q;
        out_data_d = out_data_q;
        out_id_d   = out_id_q;
        finished_d = finished_q;
        if (grant_v) begin
            out_v_d    = 1'b1;
            out_addr_d = sel_addr;
            out_data_d = sel_data;
            out_id_d   = grant_id;
            if (sel_finish) begin
                finished_d = finished_q | grant;
            end
        end else if (xfer) begin
            out_v_d = 1'b0;
        end
    end

    // DRAIN is entered on the same edge that captures the last finish packet,
    // so DONE follows on the first cycle the register is observed empty.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            PRINT_ARB_RUN:   if (&finished_d) state_d = PRINT_ARB_DRAIN;
            PRINT_ARB_DRAIN: if (!out_v_q)    state_d = PRINT_ARB_DONE;
            PRINT_ARB_DONE:  state_d = PRINT_ARB_DONE;
            default:         state_d = PRINT_ARB_RUN;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= PRINT_ARB_RUN;
            finished_q <= '0;
            out_v_q    <= 1'b0;
            out_addr_q <= '0;
            out_data_q <= '0;
            out_id_q   <= '0;
        end else begin
            state_q    <= state_d;
            finished_q <= finished_d;
            out_v_q    <= out_v_d;
            out_addr_q <= out_addr_d;
            out_data_q <= out_data_d;
            out_id_q   <= out_id_d;
        end
    end

    assign out_v_o    = out_v_q;
    assign out_addr_o = out_addr_q;
    assign out_data_o = out_data_q;
    assign out_id_o   = out_id_q;
    assign finished_o = finished_q;
    assign done_o     = (state_q == PRINT_ARB_DONE);

endmodule

// File: doc/bsg_manycore_print_arbiter.md
BSG_MANYCORE_PRINT_ARBITER -- requirements
Module: bsg_manycore_print_arbiter

Interface
REQ-001 The block SHALL have parameter num_req_p, default 4, giving the number of print requesters, legal range 2..16.
REQ-002 The block SHALL have parameter addr_width_p, default 32, giving the packet address width.
REQ-003 The block SHALL have parameter data_width_p, default 32, giving the packet data width.
REQ-004 The block SHALL have parameter finish_code_p, default 32'hCAFE_C0DE, giving the data value that marks a requester finished.
REQ-005 The block SHALL use one clock and an asynchronous active-low reset, with ports clk_i and reset_n_i.
REQ-006 The block SHALL have these ports (name, direction, width, meaning):
- clk_i, in, 1, clock
- reset_n_i, in, 1, async active-low reset
- req_v_i, in, num_req_p, per-requester packet valid
- req_addr_i, in, num_req_p*addr_width_p, per-requester address, requester i in slice i
- req_data_i, in, num_req_p*data_width_p, per-requester data, requester i in slice i
- req_yumi_o, out, num_req_p, one-hot packet consume
- out_v_o, out, 1, output packet valid
- out_addr_o, out, addr_width_p, output address
- out_data_o, out, data_width_p, output data
- out_id_o, out, clog2(num_req_p), source requester index
- out_ready_i, in, 1, sink ready
- finished_o, out, num_req_p, per-requester finished flags
- done_o, out, 1, all requesters finished and output drained

Function
REQ-007 The block SHALL hold a single-entry output register; a transfer SHALL occur on a cycle with out_v_o=1 and out_ready_i=1.
REQ-008 The output register SHALL be able to load on a cycle when it is empty or a transfer occurs on that cycle, giving full throughput of one packet per cycle.
REQ-009 req_yumi_o SHALL be at most one-hot, SHALL assert only for a requester with req_v_i=1, and SHALL depend combinationally on req_v_i.
REQ-010 Arbitration SHALL be round-robin: after a grant to requester g, priority SHALL go to g+1, g+2, ... (modulo num_req_p). After reset, requester 0 SHALL have highest priority.
REQ-011 The priority pointer SHALL advance only on a cycle where a grant occurs.
REQ-012 A granted packet SHALL appear on out_v_o/out_addr_o/out_data_o/out_id_o the cycle after its yumi, which is 1-cycle latency.
REQ-013 Output fields SHALL stay stable while out_v_o=1 and out_ready_i=0.
REQ-014 When a granted packet has data equal to finish_code_p, finished_o[i] SHALL set on the next edge and remain set (sticky); the finish packet itself SHALL still be forwarded.
REQ-015 A requester with finished_o[i]=1 SHALL be excluded from arbitration, so its later packets are never consumed.
REQ-016 The block SHALL implement an FSM with three states:
- RUN: arbitration is enabled.
- DRAIN: entered from RUN when all finished_o bits become 1. Arbitration is disabled and the block waits for the output register to empty.
- DONE: entered from DRAIN when out_v_o=0. done_o=1, req_yumi_o=0, and the state is terminal until reset.
REQ-017 When the last finish packet is granted and is simultaneously transferred on the following cycle, the transition DRAIN to DONE SHALL occur on the first cycle out_v_o is 0.
REQ-018 If all requesters are valid on every cycle, each SHALL receive exactly one grant per num_req_p grants.

Reset
REQ-019 While reset_n_i=0, the block SHALL hold out_v_o=0, req_yumi_o=0, finished_o=0, done_o=0, out_id_o=0, the pointer at 0 and the FSM in RUN.
REQ-020 Assertion of reset mid-transfer SHALL discard the output register contents immediately, asynchronously.
REQ-021 Reset deassertion SHALL be assumed synchronous to clk_i by the integrator, and the first grant SHALL be possible on the first edge after deassertion.

Structure
REQ-022 The FSM state enum SHALL reside in the shared package bsg_manycore_pkg as bsg_print_arb_state_e.
REQ-023 The round-robin grant logic SHALL be a single sub-module, bsg_arb_round_robin, taking request and enable inputs, producing a one-hot grant, and advancing its pointer on yumi.
REQ-024 The output register and the FSM SHALL be inline in bsg_manycore_print_arbiter.

Verification
REQ-025 The bench SHALL cover these directed scenarios, with num_req_p=4:
- Round-robin: hold all req_v_i=4'b1111 with out_ready_i=1 -> out_id_o sequence 0,1,2,3,0 on consecutive cycles.
- Backpressure: load addr=0x10, data=0x55 from requester 2, hold out_ready_i=0 for 5 cycles -> out_v_o stays 1, fields stable, no further yumi, then one transfer when ready rises.
- Finish masking: requester 1 sends 0xCAFEC0DE, then holds a valid packet 0x1234 -> finished_o=4'b0010, the finish packet is forwarded, requester 1 is never yumi'd again, and the others keep being served.
- Completion: all four send finish codes while out_ready_i is toggling -> done_o rises only after the last finish packet transfers, and req_yumi_o=0 thereafter.
- Reset mid-operation: assert reset_n_i=0 between edges with out_v_o=1 -> out_v_o=0 and finished_o=0 immediately, and after release requester 0 is granted first.
- Single requester: only requester 3 valid -> granted every cycle at full throughput.
